lb_scheduler: RTL and testbench

LB_SCHEDULER -- requirements
Module: lb_scheduler

---
 rtl/lb_pkg.sv | 24 ++
 rtl/line_counter.sv | 32 +++
 rtl/lb_scheduler.sv | 139 +++++++++++++
 tb/tb_lb_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared definitions for the line-buffer scheduler: buffer count, FSM codes
// and the buffer-mask helpers used by the write and read sides.
package lb_pkg;

    localparam int NUM_LB = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [NUM_LB-1:0] onehot_lb(input logic [1:0] idx);
        logic [NUM_LB-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

    // A window spans three consecutive buffers starting at the oldest line, modulo 4.
    function automatic logic [NUM_LB-1:0] read_mask(input logic [1:0] base);
        return onehot_lb(base) | onehot_lb(base + 2'd1) | onehot_lb(base + 2'd2);
    endfunction

endpackage

// File: rtl/line_counter.sv
// Column counter for one side of the scheduler; line_done flags the advance
// that consumes the last column of a line.
module line_counter #(
    parameter  int IMG_W = 512,
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [CW-1:0] col,
    output logic          line_done
);

    logic [CW-1:0] r_col;
    logic          w_at_last;

    assign w_at_last = (r_col == CW'(IMG_W - 1));
    assign line_done = i_advance & w_at_last;
    assign col       = r_col;

    always_ff @(posedge Clk) begin
        if (Rst || i_clear) begin
            r_col <= '0;
        end else if (line_done) begin
            r_col <= '0;
        end else if (i_advance) begin
            r_col <= r_col + CW'(1);
        end
    end

endmodule

// File: rtl/lb_scheduler.sv
// Schedules pixel writes into four rotating line buffers and 3x3 window reads
// out of them, tracking how many complete lines are resident.
module lb_scheduler
    import lb_pkg::*;
#(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start_in,
    input  logic              pixel_valid_in,
    output logic              pixel_ready_out,
    input  logic              dma_ready_in,
    output logic [NUM_LB-1:0] wr_en_lb,
    output logic [NUM_LB-1:0] rd_en_lb,
    output logic [1:0]        rd_sel,
    output logic              window_valid_out,
    output logic              T_last,
    output logic              frame_done,
    output logic              busy
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int LW = $clog2(IMG_H + 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [1:0]    r_wr_buf;
    logic [1:0]    r_rd_buf;
    logic [LW-1:0] r_lines_written;
    logic [LW-1:0] r_rows_read;
    logic [LW-1:0] w_rows_read_next;
    logic [2:0]    r_occupancy;
    logic [2:0]    w_occupancy_next;
    logic          r_window_valid;
    logic          w_window_valid_next;
    logic [CW-1:0] w_wr_col;
    logic [CW-1:0] w_rd_col;
    logic          w_xfer;
    logic          w_accept;
    logic          w_wr_line_done;
    logic          w_rd_line_done;
    logic          w_clear;
    logic          w_unused_wr_col;

    assign w_clear = (r_state == ST_DONE);

    // Outputs are gated by Rst so they read zero for the whole reset cycle.
    assign pixel_ready_out  = !Rst && (r_state == ST_RUN) && (r_occupancy < 3'd4);
    assign w_xfer           = pixel_valid_in && pixel_ready_out;
    assign wr_en_lb         = w_xfer ? onehot_lb(r_wr_buf) : '0;
    assign window_valid_out = !Rst && r_window_valid;
    assign w_accept         = window_valid_out && dma_ready_in;
    assign rd_en_lb         = w_accept ? read_mask(r_rd_buf) : '0;
    assign rd_sel           = Rst ? 2'd0 : r_rd_buf;
    assign T_last           = w_accept && (r_rows_read == LW'(IMG_H - 3))
                              && (w_rd_col == CW'(IMG_W - 1));
    assign frame_done       = !Rst && (r_state == ST_DONE);
    assign busy             = !Rst && (r_state != ST_IDLE);
    assign w_unused_wr_col  = ^w_wr_col;

    line_counter #(.IMG_W(IMG_W)) u_wr_counter (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_clear   (w_clear),
        .i_advance (w_xfer),
        .col       (w_wr_col),
        .line_done (w_wr_line_done)
    );

    line_counter #(.IMG_W(IMG_W)) u_rd_counter (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_clear   (w_clear),
        .i_advance (w_accept),
        .col       (w_rd_col),
        .line_done (w_rd_line_done)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start_in) w_next_state = ST_RUN;
            ST_RUN:   if (w_wr_line_done && (r_lines_written == LW'(IMG_H - 1)))
                          w_next_state = ST_DRAIN;
            ST_DRAIN: if (T_last) w_next_state = ST_DONE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // A write line and a read row finishing together leave occupancy as it is.
    always_comb begin
        w_occupancy_next = r_occupancy;
        if (w_wr_line_done && !w_rd_line_done) begin
            w_occupancy_next = r_occupancy + 3'd1;
        end else if (!w_wr_line_done && w_rd_line_done) begin
            w_occupancy_next = r_occupancy - 3'd1;
        end
    end

    assign w_rows_read_next    = w_rd_line_done ? (r_rows_read + LW'(1)) : r_rows_read;
    assign w_window_valid_next = ((w_next_state == ST_RUN) || (w_next_state == ST_DRAIN))
                                 && (w_occupancy_next >= 3'd3)
                                 && (w_rows_read_next < LW'(IMG_H - 2));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state         <= ST_IDLE;
            r_wr_buf        <= '0;
            r_rd_buf        <= '0;
            r_lines_written <= '0;
            r_rows_read     <= '0;
            r_occupancy     <= '0;
            r_window_valid  <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_window_valid <= w_window_valid_next;
            if (w_clear) begin
                r_wr_buf        <= '0;
                r_rd_buf        <= '0;
                r_lines_written <= '0;
                r_rows_read     <= '0;
                r_occupancy     <= '0;
            end else begin
                if (w_wr_line_done) begin
                    r_wr_buf        <= r_wr_buf + 2'd1;
                    r_lines_written <= r_lines_written + LW'(1);
                end
                if (w_rd_line_done) begin
                    r_rd_buf <= r_rd_buf + 2'd1;
                end
                r_rows_read <= w_rows_read_next;
                r_occupancy <= w_occupancy_next;
            end
        end
    end

endmodule

// File: tb/tb_lb_scheduler.sv
// Bench for lb_scheduler at IMG_W=8, IMG_H=6: frame scenarios, a full stall,
// and a mid-frame reset, with windows and writes checked against queued expectations.
module tb_lb_scheduler;

    localparam int IMG_W     = 8;
    localparam int IMG_H     = 6;
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int FRAME_WIN = IMG_W * (IMG_H - 2);
    localparam int BUDGET    = 1000;

    localparam int MODE_ONE    = 0;
    localparam int MODE_TOGGLE = 1;
    localparam int MODE_RANDOM = 2;
    localparam int MODE_ZERO   = 3;

    typedef struct {
        int validMode;
        int dmaMode;
        int expPixels;
        int expWindows;
        int expValidDelay;
        int expPixSpan;
    } vector_t;

    typedef struct {
        logic [3:0] rdMask;
        logic [1:0] sel;
        logic       last;
    } window_t;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       start_in;
    logic       pixel_valid_in;
    logic       pixel_ready_out;
    logic       dma_ready_in;
    logic [3:0] wr_en_lb;
    logic [3:0] rd_en_lb;
    logic [1:0] rd_sel;
    logic       window_valid_out;
    logic       T_last;
    logic       frame_done;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int cycleCnt, pixCnt, winCnt, doneCnt, tlastCnt;
    int pix24Cycle, firstValidCycle, lastCycle, doneCycle, firstPixCycle, lastPixCycle;
    bit runFlag;

    logic [3:0] wrQ[$];
    window_t    winQ[$];
    logic [3:0] maskTbl[4];
    vector_t    vectors[4];

    always #5 Clk = ~Clk;

    lb_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .start_in         (start_in),
        .pixel_valid_in   (pixel_valid_in),
        .pixel_ready_out  (pixel_ready_out),
        .dma_ready_in     (dma_ready_in),
        .wr_en_lb         (wr_en_lb),
        .rd_en_lb         (rd_en_lb),
        .rd_sel           (rd_sel),
        .window_valid_out (window_valid_out),
        .T_last           (T_last),
        .frame_done       (frame_done),
        .busy             (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, $signed(actual), $signed(expected), $time);
        end
    endtask

    function automatic logic pickBit(input int mode, input int c);
        case (mode)
            MODE_ONE:    return 1'b1;
            MODE_TOGGLE: return (c % 2) == 0;
            MODE_RANDOM: return 1'($urandom_range(0, 1));
            default:     return 1'b0;
        endcase
    endfunction

    task automatic resetCounters();
        cycleCnt = 0; pixCnt = 0; winCnt = 0; doneCnt = 0; tlastCnt = 0;
        pix24Cycle = -1; firstValidCycle = -1; lastCycle = -1; doneCycle = -1;
        firstPixCycle = -1; lastPixCycle = -1;
        runFlag = 0;
        wrQ.delete();
        winQ.delete();
    endtask

    // Expected write enables and window reads of one frame, in order.
    task automatic applyStimulus();
        logic [3:0] oh;
        window_t    w;
        int         row;
        resetCounters();
        for (int p = 0; p < FRAME_PIX; p++) begin
            oh = 4'b0001 << ((p / IMG_W) % 4);
            wrQ.push_back(oh);
        end
        for (int k = 0; k < FRAME_WIN; k++) begin
            row      = k / IMG_W;
            w.rdMask = maskTbl[row % 4];
            w.sel    = 2'(row % 4);
            w.last   = (k == FRAME_WIN - 1);
            winQ.push_back(w);
        end
        @(posedge Clk); #1;
        start_in = 1'b1;
        @(posedge Clk); #1;
        start_in = 1'b0;
        runFlag  = 1;
    endtask

    task automatic runFrame(input int validMode, input int dmaMode);
        int c;
        c = 0;
        while (doneCnt == 0 && c < BUDGET) begin
            pixel_valid_in = pickBit(validMode, c);
            dma_ready_in   = pickBit(dmaMode, c);
            @(posedge Clk); #1;
            c++;
        end
        pixel_valid_in = 1'b0;
        dma_ready_in   = 1'b0;
        checkOutput("frame_within_budget", c < BUDGET, 1);
        repeat (2) begin @(posedge Clk); #1; end
    endtask

    task automatic checkFrameEnd(input vector_t v);
        checkOutput("pixels", pixCnt, v.expPixels);
        checkOutput("windows", winCnt, v.expWindows);
        checkOutput("t_last_count", tlastCnt, 1);
        checkOutput("frame_done_count", doneCnt, 1);
        checkOutput("first_valid_delay", firstValidCycle - pix24Cycle, v.expValidDelay);
        checkOutput("done_after_last", doneCycle - lastCycle, 1);
        if (v.expPixSpan >= 0) checkOutput("pixel_span", lastPixCycle - firstPixCycle, v.expPixSpan);
        checkOutput("busy_after_frame", busy, 0);
        checkOutput("wr_queue_left", wrQ.size(), 0);
        checkOutput("win_queue_left", winQ.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_pixel_ready"}, pixel_ready_out, 0);
        checkOutput({tag, "_wr_en"}, wr_en_lb, 0);
        checkOutput({tag, "_rd_en"}, rd_en_lb, 0);
        checkOutput({tag, "_rd_sel"}, rd_sel, 0);
        checkOutput({tag, "_window_valid"}, window_valid_out, 0);
        checkOutput({tag, "_t_last"}, T_last, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    // Occupancy and read progress are rebuilt from observed transfers each cycle.
    always @(negedge Clk) begin : monitor
        int      linesW;
        int      rowsR;
        int      occ;
        window_t w;
        if (!Rst) begin
            linesW = pixCnt / IMG_W;
            rowsR  = winCnt / IMG_W;
            occ    = linesW - rowsR;
            cycleCnt++;
            checkOutput("pixel_ready_out", pixel_ready_out, runFlag && (linesW < IMG_H) && (occ < 4));
            checkOutput("window_valid_out", window_valid_out, (occ >= 3) && (rowsR < IMG_H - 2));
            checkOutput("rd_sel", rd_sel, rowsR % 4);
            if (pixel_valid_in && pixel_ready_out) begin
                checkOutput("wr_pending", wrQ.size() > 0, 1);
                if (wrQ.size() > 0) checkOutput("wr_en_lb", wr_en_lb, wrQ.pop_front());
                if (pixCnt == 0) firstPixCycle = cycleCnt;
                pixCnt++;
                lastPixCycle = cycleCnt;
                if (pixCnt == 3 * IMG_W) pix24Cycle = cycleCnt;
            end else begin
                checkOutput("wr_en_lb_idle", wr_en_lb, 0);
            end
            if (window_valid_out && firstValidCycle < 0) firstValidCycle = cycleCnt;
            if (window_valid_out && dma_ready_in) begin
                checkOutput("win_pending", winQ.size() > 0, 1);
                if (winQ.size() > 0) begin
                    w = winQ.pop_front();
                    checkOutput("rd_en_lb", rd_en_lb, w.rdMask);
                    checkOutput("rd_sel_accept", rd_sel, w.sel);
                    checkOutput("T_last", T_last, w.last);
                end
                winCnt++;
                if (T_last) begin
                    tlastCnt++;
                    lastCycle = cycleCnt;
                end
            end else begin
                checkOutput("rd_en_lb_idle", rd_en_lb, 0);
                checkOutput("T_last_idle", T_last, 0);
            end
            if (frame_done) begin
                doneCnt++;
                doneCycle = cycleCnt;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vector_t stallVec;
        int      c;

        maskTbl[0] = 4'b0111;
        maskTbl[1] = 4'b1110;
        maskTbl[2] = 4'b1101;
        maskTbl[3] = 4'b1011;
        vectors[0] = '{MODE_ONE,    MODE_ONE,    FRAME_PIX, FRAME_WIN, 1, FRAME_PIX - 1};
        vectors[1] = '{MODE_ONE,    MODE_TOGGLE, FRAME_PIX, FRAME_WIN, 1, -1};
        vectors[2] = '{MODE_TOGGLE, MODE_ONE,    FRAME_PIX, FRAME_WIN, 1, -1};
        vectors[3] = '{MODE_RANDOM, MODE_RANDOM, FRAME_PIX, FRAME_WIN, 1, -1};
        stallVec   = '{MODE_ONE,    MODE_ZERO,   FRAME_PIX, FRAME_WIN, 1, -1};

        Rst = 1'b1; start_in = 1'b1; pixel_valid_in = 1'b1; dma_ready_in = 1'b1;
        resetCounters();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkResetOutputs("por");
        @(posedge Clk); #1;
        Rst = 1'b0; start_in = 1'b0; pixel_valid_in = 1'b0; dma_ready_in = 1'b0;
        @(posedge Clk); #1;
        checkOutput("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            runFrame(vectors[i].validMode, vectors[i].dmaMode);
            checkFrameEnd(vectors[i]);
        end

        // Downstream stalled: four lines fill, then the upstream is back-pressured.
        applyStimulus();
        for (int i = 0; i < 60; i++) begin
            pixel_valid_in = 1'b1;
            dma_ready_in   = 1'b0;
            @(posedge Clk); #1;
        end
        checkOutput("stall_pixels", pixCnt, 4 * IMG_W);
        checkOutput("stall_ready", pixel_ready_out, 0);
        checkOutput("stall_window_valid", window_valid_out, 1);
        checkOutput("stall_windows", winCnt, 0);
        runFrame(MODE_ONE, MODE_ONE);
        checkFrameEnd(stallVec);

        // Reset after 20 windows abandons the frame until a fresh start.
        applyStimulus();
        c = 0;
        while (winCnt < 20 && c < BUDGET) begin
            pixel_valid_in = 1'b1;
            dma_ready_in   = 1'b1;
            @(posedge Clk); #1;
            c++;
        end
        checkOutput("reached_20_windows", winCnt, 20);
        Rst = 1'b1;
        @(negedge Clk);
        checkResetOutputs("mid_reset");
        @(posedge Clk); #1;
        Rst = 1'b0;
        resetCounters();
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
        end
        checkOutput("post_reset_pixels", pixCnt, 0);
        checkOutput("post_reset_busy", busy, 0);
        pixel_valid_in = 1'b0;
        dma_ready_in   = 1'b0;
        applyStimulus();
        runFrame(MODE_ONE, MODE_ONE);
        checkFrameEnd(vectors[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
